audio_fir_sequencer: RTL
========================

# audio_fir_sequencer

Post-distortion filter stage of the audio path. Once the distorted record (DEPTH 8-bit samples) is in the sample BRAM, this block sweeps it in order, runs a causal 5-tap weighted moving-average over the stream, and writes one filtered sample per input address into the output BRAM. Edge handling is built in: history before address 0 is zero-padded, so the first four outputs need no special casing in the top level.

## Interface
- DEPTH, 1024, samples per record; power of two.
- AW, 10, address width, log2(DEPTH).
- DW, 8, sample width, unsigned.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep; sampled only in IDLE.
- bypass  in  1  latched at start; 1 = copy input to output unfiltered.
- rd_en  out  1  read strobe to sample BRAM.
- rd_addr  out  AW  read address.
- rd_data  in  DW  BRAM read data, valid the cycle after rd_en (registered output, 1-cycle latency).
- wr_en  out  1  write strobe to output BRAM.
- wr_addr  out  AW  write address.
- wr_data  out  DW  filtered sample.
- busy  out  1  high from the cycle after start is accepted until the final write completes.
- done  out  1  one-cycle pulse after the last write.

## Operation
- Window registers x0 (newest) to x4 (oldest), DW bits each; all cleared on start and on rst.
- Filter: acc = x0 + 2·x1 + 2·x2 + 2·x3 + x4, 11 bits unsigned, never overflows (max 2040). y = acc[10:3], a truncating divide by 8. Gain is 1.0 at DC.
- bypass=1: y = x0. The window still shifts.
- FSM states:
  - IDLE: start → RD. Clear window, n=0, latch bypass.
  - RD: rd_en=1, rd_addr=n → CAP.
  - CAP: shift rd_data into x0 (x0→x1 … x3→x4, x4 dropped); register y → WR.
  - WR: wr_en=1, wr_addr=n, wr_data=y. If n==DEPTH-1 → DONE, else n++ → RD.
  - DONE: done=1 → IDLE.
- Causal filter: output n depends only on inputs n..n-4, so the tail needs no end-of-record handling. Indices below 0 read as 0.
- start in any non-IDLE state is ignored; bypass changes mid-sweep are ignored.
- Counter n never wraps. The sweep terminates at DEPTH-1.

## Timing
- Reset values: rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, busy=0, done=0, state IDLE, window=0, n=0.
- All outputs are registered.
- start sampled high at edge k → RD during cycle k+1 (rd_en high, busy high).
- Each sample takes 3 cycles (RD, CAP, WR). The write for sample n occurs in cycle k+3+3n.
- Last write (n=DEPTH-1) in cycle k+3·DEPTH. done high in cycle k+3·DEPTH+1, when busy is already low.
- DEPTH=1024: 3072 busy cycles.
- rd_en and wr_en are never high in the same cycle. Each is high for exactly 1 cycle per sample.
- rst mid-sweep: at the next edge all outputs take their reset values and no further rd_en or wr_en occurs. Output BRAM contents already written are left as is. A new start afterwards runs a full sweep from n=0 with a cleared window.
- rst and start high together: rst wins, and the block stays in IDLE.

## Test plan
- Impulse: input[0]=255, all others 0, bypass=0 → out[0]=31, out[1]=63, out[2]=63, out[3]=63, out[4]=31, out[5..1023]=0. done exactly 3073 cycles after the start edge.
- Step: all inputs 200 → out[0]=25, out[1]=75, out[2]=125, out[3]=175, out[4..1023]=200 (checks zero-padded warm-up).
- Bypass: input[n]=n[7:0], bypass=1 → out[n]=n[7:0] for all n. bypass dropped to 0 mid-sweep → output still unfiltered.
- Re-trigger: start pulsed again at cycles 10 and 2000 of a sweep → single sweep, exactly 1024 wr_en pulses, one done pulse.
- Reset mid-run: rst asserted during WR of n=500 → no wr_en after that cycle, busy=0 next cycle. Restart with input[0]=255 reproduces impulse result with no stale window data.
- Max value: all inputs 255 → out[4..1023]=255, with no overflow/wrap in acc.

Source files
------------

// File: rtl/audio_fir_sequencer.sv
// audio_fir_sequencer
//
// Sweeps a DEPTH-sample record out of the sample BRAM in address order. Each sample
// goes through a causal 5-tap weighted moving average (1,2,2,2,1)/8, and one result
// is written per address into the output BRAM. History before address 0 reads as
// zero, because the window is cleared when a sweep starts.
//
// Ports:
//   clk, rst    rising-edge clock; synchronous active-high reset
//   start       one-cycle pulse; begins a sweep (accepted only while idle)
//   bypass      latched at start; 1 = copy the input to the output unfiltered
//   rd_en       read strobe to the sample BRAM
//   rd_addr     read address
//   rd_data     BRAM read data, valid the cycle after rd_en
//   wr_en       write strobe to the output BRAM
//   wr_addr     write address
//   wr_data     filtered sample
//   busy        high from the cycle after start until the last write
//   done        one-cycle pulse after the last write
module audio_fir_sequencer #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bypass,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StDone} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e             stateQ, stateD;
  logic [AW-1:0]      nQ, nD;
  logic [4:0][DW-1:0] winQ, winD;
  logic               bypassQ, bypassD;
  logic               rdEnD, wrEnD, busyD, doneD;
  logic [AW-1:0]      rdAddrD, wrAddrD;
  logic [DW-1:0]      wrDataD;
  logic [DW+2:0]      acc;

  // The sum covers the window as it will look after the shift: the incoming sample
  // becomes the newest tap and the old x3 becomes the oldest (x4) tap.
  always_comb begin
    acc = (DW+3)'(rd_data)
        + ((DW+3)'(winQ[0]) << 1)
        + ((DW+3)'(winQ[1]) << 1)
        + ((DW+3)'(winQ[2]) << 1)
        + (DW+3)'(winQ[3]);
  end

  // Every output is registered. The next-state logic therefore also computes the
  // output values that belong to the state being entered.
  always_comb begin
    stateD  = stateQ;
    nD      = nQ;
    winD    = winQ;
    bypassD = bypassQ;
    rdEnD   = 1'b0;
    wrEnD   = 1'b0;
    busyD   = 1'b0;
    doneD   = 1'b0;
    rdAddrD = rd_addr;
    wrAddrD = wr_addr;
    wrDataD = wr_data;

    unique case (stateQ)
      StIdle: begin
        if (start) begin
          stateD  = StRd;
          nD      = '0;
          winD    = '0;
          bypassD = bypass;
          rdEnD   = 1'b1;
          rdAddrD = '0;
          busyD   = 1'b1;
        end
      end
      StRd: begin
        stateD = StCap;
        busyD  = 1'b1;
      end
      StCap: begin
        stateD  = StWr;
        winD    = {winQ[3:0], rd_data};
        wrDataD = bypassQ ? rd_data : acc[DW+2:3];
        wrEnD   = 1'b1;
        wrAddrD = nQ;
        busyD   = 1'b1;
      end
      StWr: begin
        if (nQ == LastAddr) begin
          stateD = StDone;
          doneD  = 1'b1;
        end else begin
          stateD  = StRd;
          nD      = nQ + 1'b1;
          rdEnD   = 1'b1;
          rdAddrD = nQ + 1'b1;
          busyD   = 1'b1;
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= StIdle;
      nQ      <= '0;
      winQ    <= '0;
      bypassQ <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      nQ      <= nD;
      winQ    <= winD;
      bypassQ <= bypassD;
      rd_en   <= rdEnD;
      rd_addr <= rdAddrD;
      wr_en   <= wrEnD;
      wr_addr <= wrAddrD;
      wr_data <= wrDataD;
      busy    <= busyD;
      done    <= doneD;
    end
  end

endmodule
